// File: rtl/ad_pkg.sv
// ad_pkg: shared sample width, FIFO word layout and capture FSM states
package ad_pkg;

    localparam int AD_DW = 12;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_VSKIP,
        ST_HSKIP,
        ST_ACTIVE,
        ST_HWAIT
    } cap_state_t;

    // FIFO word is {sof, sol, eol, ch2, ch1}
    function automatic int word_w(input int dw);
        return 2 * dw + 3;
    endfunction

    function automatic int sof_bit(input int dw);
        return 2 * dw + 2;
    endfunction

    function automatic int sol_bit(input int dw);
        return 2 * dw + 1;
    endfunction

    function automatic int eol_bit(input int dw);
        return 2 * dw;
    endfunction

endpackage

// File: rtl/ad_sync_fifo.sv
// ad_sync_fifo: single-clock first-word-fall-through FIFO
module ad_sync_fifo #(
    parameter int WIDTH = 8,
    parameter int AW    = 4
) (
    input  logic             clk,
    input  logic             reset_n,
    input  logic             push,
    input  logic             pop,
    input  logic [WIDTH-1:0] din,
    output logic [WIDTH-1:0] dout,
    output logic             full,
    output logic             empty,
    output logic [AW:0]      count
);

    localparam int DEPTH = 1 << AW;

    logic [WIDTH-1:0] mem [DEPTH];
    logic [AW-1:0]    wr_ptr, rd_ptr;
    logic [AW:0]      cnt;
    logic             do_push, do_pop;

    assign full    = (cnt == DEPTH[AW:0]);
    assign empty   = (cnt == '0);
    assign count   = cnt;
    assign dout    = mem[rd_ptr];
    assign do_pop  = pop && !empty;
    assign do_push = push && (!full || pop);

    // storage array, no reset needed since reads are qualified by count
    always_ff @(posedge clk) begin
        if (do_push) mem[wr_ptr] <= din;
    end

    // pointer and occupancy bookkeeping
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            cnt    <= '0;
        end else begin
            if (do_push) wr_ptr <= wr_ptr + 1'b1;
            if (do_pop) rd_ptr <= rd_ptr + 1'b1;
            cnt <= cnt + (AW + 1)'(do_push) - (AW + 1)'(do_pop);
        end
    end

endmodule

// File: rtl/ad_line_capture.sv
// ad_line_capture: windowed line/frame capture of dual-channel ADC samples into a marked stream
module ad_line_capture
    import ad_pkg::*;
#(
    parameter int DW       = AD_DW,
    parameter int H_OFFSET = 4,
    parameter int H_ACTIVE = 16,
    parameter int V_OFFSET = 2,
    parameter int V_ACTIVE = 4,
    parameter int FIFO_AW  = 5
) (
    input  logic            clk,
    input  logic            reset_n,
    input  logic            sample_en_i,
    input  logic [DW-1:0]   ch1_i,
    input  logic [DW-1:0]   ch2_i,
    input  logic            hs_i,
    input  logic            vs_i,
    output logic [2*DW-1:0] data_o,
    output logic            valid_o,
    input  logic            ready_i,
    output logic            sof_o,
    output logic            sol_o,
    output logic            eol_o,
    output logic            ovf_o,
    output logic            line_err_o
);

    localparam int WW    = word_w(DW);
    localparam int SOF_B = sof_bit(DW);
    localparam int SOL_B = sol_bit(DW);
    localparam int EOL_B = eol_bit(DW);

    // state entered at the start of every active line and of every frame
    localparam cap_state_t HSTART = (H_OFFSET == 0) ? ST_ACTIVE : ST_HSKIP;
    localparam cap_state_t FSTART = (V_OFFSET == 0) ? HSTART : ST_VSKIP;

    cap_state_t     state, state_nxt;
    logic           hs_q, vs_q, hs_rise, vs_rise;
    logic [15:0]    line_cnt, skip_cnt, pix_cnt, act_cnt;
    logic           in_line, hs_end, line_done, last_line;
    logic           push, drop;
    logic [WW-1:0]  wr_word, rd_word, out_word;
    logic           fifo_full, fifo_empty;
    logic [FIFO_AW:0] fifo_count;

    assign hs_rise   = hs_i && !hs_q;
    assign vs_rise   = vs_i && !vs_q;
    assign in_line   = state inside {ST_HSKIP, ST_ACTIVE, ST_HWAIT};
    assign hs_end    = hs_rise && in_line;
    assign last_line = (act_cnt == 16'(V_ACTIVE - 1));
    assign line_done = (state == ST_HWAIT) ||
                       (push && pix_cnt == 16'(H_ACTIVE - 1));
    assign drop      = push && fifo_full && !ready_i;

    // sync inputs idle high, so reset them high to avoid a phantom edge
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            hs_q <= 1'b1;
            vs_q <= 1'b1;
        end else begin
            hs_q <= hs_i;
            vs_q <= vs_i;
        end
    end

    // capture FSM state register
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) state <= ST_IDLE;
        else state <= state_nxt;
    end

    // next state: VS beats HS, HS ending a line beats in-line progress
    always_comb begin
        state_nxt = state;
        if (vs_rise)
            state_nxt = FSTART;
        else if (hs_end)
            state_nxt = last_line ? ST_IDLE : HSTART;
        else if (state == ST_VSKIP && hs_rise && line_cnt == 16'(V_OFFSET - 1))
            state_nxt = HSTART;
        else if (state == ST_HSKIP && sample_en_i && skip_cnt == 16'(H_OFFSET - 1))
            state_nxt = ST_ACTIVE;
        else if (state == ST_ACTIVE && sample_en_i && pix_cnt == 16'(H_ACTIVE - 1))
            state_nxt = ST_HWAIT;
    end

    // FSM outputs: push strobe and the marked FIFO word
    always_comb begin
        push           = (state == ST_ACTIVE) && sample_en_i;
        wr_word        = '0;
        wr_word[2*DW-1:0] = {ch2_i, ch1_i};
        wr_word[SOF_B] = (pix_cnt == '0) && (act_cnt == '0);
        wr_word[SOL_B] = (pix_cnt == '0);
        wr_word[EOL_B] = (pix_cnt == 16'(H_ACTIVE - 1));
    end

    // geometry counters and sticky flags; drops still advance the counters
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            line_cnt   <= '0;
            skip_cnt   <= '0;
            pix_cnt    <= '0;
            act_cnt    <= '0;
            ovf_o      <= 1'b0;
            line_err_o <= 1'b0;
        end else if (vs_rise) begin
            line_cnt   <= '0;
            skip_cnt   <= '0;
            pix_cnt    <= '0;
            act_cnt    <= '0;
            ovf_o      <= 1'b0;
            line_err_o <= 1'b0;
        end else begin
            if (state == ST_VSKIP && hs_rise) line_cnt <= line_cnt + 1'b1;
            if (hs_end) begin
                act_cnt  <= act_cnt + 1'b1;
                skip_cnt <= '0;
                pix_cnt  <= '0;
                if (!line_done) line_err_o <= 1'b1;
            end else begin
                if (state == ST_HSKIP && sample_en_i) skip_cnt <= skip_cnt + 1'b1;
                if (push) pix_cnt <= pix_cnt + 1'b1;
            end
            if (drop) ovf_o <= 1'b1;
        end
    end

    ad_sync_fifo #(
        .WIDTH(WW),
        .AW   (FIFO_AW)
    ) u_fifo (
        .clk    (clk),
        .reset_n(reset_n),
        .push   (push),
        .pop    (ready_i),
        .din    (wr_word),
        .dout   (rd_word),
        .full   (fifo_full),
        .empty  (fifo_empty),
        .count  (fifo_count)
    );

    // outputs read as zero whenever nothing is queued
    assign out_word = (fifo_count != '0) ? rd_word : '0;
    assign valid_o  = !fifo_empty;
    assign data_o   = out_word[2*DW-1:0];
    assign sof_o    = out_word[SOF_B];
    assign sol_o    = out_word[SOL_B];
    assign eol_o    = out_word[EOL_B];

endmodule

// File: tb/tb_ad_line_capture.sv
// tb_ad_line_capture: directed checks of windowing, markers, backpressure, sync handling and reset
module tb_ad_line_capture;

    logic        clk = 1'b0;
    logic        reset_n = 1'b0;
    logic        sample_en_i = 1'b0;
    logic [11:0] ch1_i = '0;
    logic [11:0] ch2_i = '0;
    logic        hs_i = 1'b1;
    logic        vs_i = 1'b1;
    logic [23:0] data_o;
    logic        valid_o;
    logic        ready_i = 1'b1;
    logic        sof_o, sol_o, eol_o, ovf_o, line_err_o;

    int tests = 0;
    int fails = 0;
    int base;
    logic [26:0] got [$];

    ad_line_capture dut (
        .clk        (clk),
        .reset_n    (reset_n),
        .sample_en_i(sample_en_i),
        .ch1_i      (ch1_i),
        .ch2_i      (ch2_i),
        .hs_i       (hs_i),
        .vs_i       (vs_i),
        .data_o     (data_o),
        .valid_o    (valid_o),
        .ready_i    (ready_i),
        .sof_o      (sof_o),
        .sol_o      (sol_o),
        .eol_o      (eol_o),
        .ovf_o      (ovf_o),
        .line_err_o (line_err_o)
    );

    always #5 clk = ~clk;

    // record every accepted word, sampled half a cycle before the transfer edge
    always @(negedge clk) begin
        if (valid_o && ready_i) got.push_back({sof_o, sol_o, eol_o, data_o});
    end

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    task automatic hs_pulse;
        hs_i = 1'b0; tick; tick;
        hs_i = 1'b1; tick;
    endtask

    task automatic vs_pulse;
        vs_i = 1'b0; tick; tick;
        vs_i = 1'b1; tick;
    endtask

    task automatic both_pulse;
        hs_i = 1'b0; vs_i = 1'b0; tick; tick;
        hs_i = 1'b1; vs_i = 1'b1; tick;
    endtask

    // n strobes of one line tagged h; ch1 = 0x0EF + sample index
    task automatic strobes(input int h, input int n, input int start);
        for (int k = 0; k < n; k++) begin
            sample_en_i = 1'b1;
            ch1_i = 12'h0EF + 12'(start + k);
            ch2_i = {4'(h), 8'(start + k)};
            tick;
        end
        sample_en_i = 1'b0;
    endtask

    // expected word for active line l (stimulus tag h), active sample k; offset 4 skipped
    function automatic logic [26:0] ew(input int l, input int h, input int k);
        logic [11:0] c1;
        logic [11:0] c2;
        c1 = 12'h0EF + 12'(4 + k);
        c2 = {4'(h), 8'(4 + k)};
        return {(l == 0 && k == 0), (k == 0), (k == 15), c2, c1};
    endfunction

    function automatic logic [26:0] out_word;
        return {sof_o, sol_o, eol_o, data_o};
    endfunction

    initial begin
        // reset state
        #3;
        chk("rst_valid", valid_o, 0);
        chk("rst_data", data_o, 0);
        chk("rst_marks", {sof_o, sol_o, eol_o}, 0);
        chk("rst_flags", {ovf_o, line_err_o}, 0);
        tick;
        reset_n = 1'b1;
        tick;

        // default frame: 6 HS lines of 30 strobes -> 4 lines x 16 samples
        base = got.size();
        vs_pulse;
        for (int h = 1; h <= 6; h++) begin
            hs_pulse;
            strobes(h, 30, 0);
        end
        repeat (5) tick;
        chk("t1_count", got.size() - base, 64);
        for (int i = 0; i < 64; i++) chk("t1_word", got[base + i], ew(i / 16, i / 16 + 2, i % 16));
        chk("t1_flags", {ovf_o, line_err_o}, 0);

        // backpressure: whole frame with ready low fills 32 entries
        ready_i = 1'b0;
        vs_pulse;
        hs_pulse;
        strobes(1, 30, 0);
        hs_pulse;
        strobes(2, 4, 0);
        chk("t2_pre_valid", valid_o, 0);
        strobes(2, 1, 4);
        chk("t2_latency", valid_o, 1);
        chk("t2_first", out_word(), ew(0, 2, 0));
        strobes(2, 25, 5);
        for (int h = 3; h <= 6; h++) begin
            hs_pulse;
            strobes(h, 30, 0);
        end
        chk("t2_ovf", ovf_o, 1);
        chk("t2_valid", valid_o, 1);
        chk("t2_hold", out_word(), ew(0, 2, 0));
        base = got.size();
        ready_i = 1'b1;
        repeat (40) tick;
        chk("t2_count", got.size() - base, 32);
        for (int i = 0; i < 32; i++) chk("t2_word", got[base + i], ew(i / 16, i / 16 + 2, i % 16));

        // short line: HS after 10 active samples
        vs_pulse;
        chk("t3_ovf_clr", ovf_o, 0);
        base = got.size();
        hs_pulse;
        strobes(1, 30, 0);
        hs_pulse;
        strobes(2, 14, 0);
        chk("t3_err_pre", line_err_o, 0);
        hs_pulse;
        chk("t3_err", line_err_o, 1);
        strobes(3, 30, 0);
        repeat (5) tick;
        chk("t3_count", got.size() - base, 26);
        for (int i = 0; i < 10; i++) chk("t3_short", got[base + i], ew(0, 2, i));
        for (int i = 0; i < 16; i++) chk("t3_full", got[base + 10 + i], ew(1, 3, i));

        // VS mid line 2 restarts the frame and clears flags
        vs_pulse;
        chk("t4_err_clr0", line_err_o, 0);
        hs_pulse;
        strobes(1, 30, 0);
        hs_pulse;
        strobes(2, 30, 0);
        hs_pulse;
        strobes(3, 10, 0);
        hs_pulse;
        chk("t4_err_set", line_err_o, 1);
        strobes(4, 10, 0);
        vs_pulse;
        chk("t4_err_clr", line_err_o, 0);
        repeat (3) tick;
        base = got.size();
        hs_pulse;
        strobes(5, 30, 0);
        chk("t4_skip", got.size() - base, 0);
        hs_pulse;
        strobes(6, 30, 0);
        repeat (3) tick;
        chk("t4_count", got.size() - base, 16);
        chk("t4_sof", got[base], ew(0, 6, 0));
        chk("t4_last", got[base + 15], ew(0, 6, 15));

        // HS and VS together while ACTIVE act as VS alone
        hs_pulse;
        strobes(7, 6, 0);
        repeat (3) tick;
        base = got.size();
        both_pulse;
        strobes(8, 30, 0);
        hs_pulse;
        strobes(9, 30, 0);
        chk("t5_vskip", got.size() - base, 0);
        chk("t5_no_err", line_err_o, 0);
        hs_pulse;
        strobes(10, 30, 0);
        repeat (3) tick;
        chk("t5_count", got.size() - base, 16);
        chk("t5_sof", got[base], ew(0, 10, 0));

        // async reset mid-ACTIVE with 5 words queued
        ready_i = 1'b0;
        vs_pulse;
        hs_pulse;
        hs_pulse;
        strobes(11, 9, 0);
        chk("t6_valid_pre", valid_o, 1);
        chk("t6_word_pre", out_word(), ew(0, 11, 0));
        #2;
        reset_n = 1'b0;
        #1;
        chk("t6_rst_valid", valid_o, 0);
        chk("t6_rst_word", out_word(), 0);
        chk("t6_rst_flags", {ovf_o, line_err_o}, 0);
        tick;
        reset_n = 1'b1;
        tick;
        ready_i = 1'b1;
        base = got.size();
        hs_pulse;
        strobes(12, 30, 0);
        repeat (3) tick;
        chk("t6_idle", got.size() - base, 0);
        chk("t6_idle_valid", valid_o, 0);
        vs_pulse;
        hs_pulse;
        hs_pulse;
        strobes(13, 30, 0);
        repeat (3) tick;
        chk("t6_count", got.size() - base, 16);
        chk("t6_sof", got[base], ew(0, 13, 0));

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
